// File: rtl/reaction_responder_pkg.sv
// Shared types and helpers for the reaction-timer self-test responder.
// State encoding, BCD limits and BCD-to-binary conversion.
package reaction_responder_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_LED = 3'd1,
    DELAY    = 3'd2,
    PRESS    = 3'd3,
    CHECK    = 3'd4
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int         BIN_W   = 10;

  function automatic logic [3:0] clamp_digit(
    input logic [3:0] d
  );
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  function automatic logic [BIN_W-1:0] bcd_to_bin(
    input logic [3:0] h,
    input logic [3:0] t,
    input logic [3:0] o
  );
    logic [BIN_W-1:0] hb;
    logic [BIN_W-1:0] tb;
    logic [BIN_W-1:0] ob;
    hb = {6'd0, h};
    tb = {6'd0, t};
    ob = {6'd0, o};
    return (hb * 10'd100) + (tb * 10'd10) + ob;
  endfunction

endpackage

// File: rtl/reaction_responder_bcd_down3.sv
// Three-digit BCD down-counter with digit clamping on load.
// Decrement saturates at 000; borrows ripple o -> t -> h.
module bcd_down3
  import reaction_responder_pkg::*;
(
  input  logic       clk,
  input  logic       ar,
  input  logic       load,
  input  logic [3:0] d_h,
  input  logic [3:0] d_t,
  input  logic [3:0] d_o,
  input  logic       dec,
  output logic       zero,
  output logic [3:0] q_h,
  output logic [3:0] q_t,
  output logic [3:0] q_o
);

  assign zero = (q_h == 4'd0) &&
                (q_t == 4'd0) &&
                (q_o == 4'd0);

  // Load clamped digits, or step down one count with BCD borrow.
  always_ff @(posedge clk) begin
    if (ar) begin
      q_h <= 4'd0;
      q_t <= 4'd0;
      q_o <= 4'd0;
    end else if (load) begin
      q_h <= clamp_digit(d_h);
      q_t <= clamp_digit(d_t);
      q_o <= clamp_digit(d_o);
    end else if (dec && !zero) begin
      if (q_o != 4'd0) begin
        q_o <= q_o - 4'd1;
      end else begin
        q_o <= BCD_MAX;
        if (q_t != 4'd0) begin
          q_t <= q_t - 4'd1;
        end else begin
          q_t <= BCD_MAX;
          q_h <= q_h - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/reaction_responder.sv
// Self-test responder: waits for the timer LED, presses stop after
// a programmed BCD delay, then grades the timer's BCD result.
module reaction_responder
  import reaction_responder_pkg::*;
#(
  parameter int PRESS_TICKS   = 50,
  parameter int TOL           = 1,
  parameter int TIMEOUT_TICKS = 4095
) (
  input  logic       clk,
  input  logic       ar,
  input  logic       tick_1k,
  input  logic       start,
  input  logic [3:0] delay_h,
  input  logic [3:0] delay_t,
  input  logic [3:0] delay_o,
  input  logic       led_in,
  input  logic [3:0] res_h,
  input  logic [3:0] res_t,
  input  logic [3:0] res_o,
  output logic       stop_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic       timeout
);

  localparam logic [11:0] TO_LAST =
    12'(TIMEOUT_TICKS - 1);
  localparam logic [7:0] PRESS_LAST =
    8'(PRESS_TICKS - 1);

  state_t state;
  state_t state_n;

  logic             led_q;
  logic             rise;
  logic [11:0]      to_cnt;
  logic [7:0]       press_cnt;
  logic [BIN_W-1:0] d_bin;

  logic load;
  logic dec;
  logic zero;
  logic to_inc;
  logic press_inc;
  logic clr;
  logic done_n;
  logic set_pass;
  logic set_fail;
  logic set_to;

  logic [3:0] q_h;
  logic [3:0] q_t;
  logic [3:0] q_o;

  logic [BIN_W-1:0] r_bin;
  logic [10:0]      r11;
  logic [10:0]      d11;
  logic [10:0]      diff;
  logic             bad;
  logic             ok;

  assign rise     = led_in & ~led_q;
  assign stop_out = (state == PRESS);

  bcd_down3 u_cnt (
    .clk  (clk),
    .ar   (ar),
    .load (load),
    .d_h  (delay_h),
    .d_t  (delay_t),
    .d_o  (delay_o),
    .dec  (dec),
    .zero (zero),
    .q_h  (q_h),
    .q_t  (q_t),
    .q_o  (q_o)
  );

  // Grade the timer result against the clamped delay, unsigned.
  always_comb begin
    r_bin = bcd_to_bin(res_h, res_t, res_o);
    r11   = {1'b0, r_bin};
    d11   = {1'b0, d_bin};
    diff  = (r11 >= d11) ? (r11 - d11)
                         : (d11 - r11);
    bad   = (res_h > BCD_MAX) ||
            (res_t > BCD_MAX) ||
            (res_o > BCD_MAX);
    ok    = (diff <= 11'(TOL)) && !bad;
  end

  // Next-state and control strobes.
  always_comb begin
    state_n   = state;
    load      = 1'b0;
    dec       = 1'b0;
    to_inc    = 1'b0;
    press_inc = 1'b0;
    clr       = 1'b0;
    done_n    = 1'b0;
    set_pass  = 1'b0;
    set_fail  = 1'b0;
    set_to    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          clr     = 1'b1;
          state_n = WAIT_LED;
        end
      end
      WAIT_LED: begin
        if (rise) begin
          state_n = DELAY;
        end else if (tick_1k) begin
          if (to_cnt == TO_LAST) begin
            set_fail = 1'b1;
            set_to   = 1'b1;
            done_n   = 1'b1;
            state_n  = IDLE;
          end else begin
            to_inc = 1'b1;
          end
        end
      end
      DELAY: begin
        if (tick_1k) begin
          if (zero) state_n = PRESS;
          else      dec     = 1'b1;
        end
      end
      PRESS: begin
        if (tick_1k) begin
          if (press_cnt == PRESS_LAST)
            state_n = CHECK;
          else
            press_inc = 1'b1;
        end
      end
      CHECK: begin
        done_n  = 1'b1;
        state_n = IDLE;
        if (ok) set_pass = 1'b1;
        else    set_fail = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and LED edge register.
  always_ff @(posedge clk) begin
    if (ar) begin
      state <= IDLE;
      led_q <= 1'b0;
    end else begin
      state <= state_n;
      led_q <= led_in;
    end
  end

  // Timeout, press counters and the latched binary delay.
  always_ff @(posedge clk) begin
    if (ar) begin
      to_cnt    <= 12'd0;
      press_cnt <= 8'd0;
      d_bin     <= '0;
    end else begin
      if (load) begin
        to_cnt <= 12'd0;
        d_bin  <= bcd_to_bin(clamp_digit(delay_h),
                             clamp_digit(delay_t),
                             clamp_digit(delay_o));
      end else if (to_inc) begin
        to_cnt <= to_cnt + 12'd1;
      end
      if (state != PRESS)
        press_cnt <= 8'd0;
      else if (press_inc)
        press_cnt <= press_cnt + 8'd1;
    end
  end

  // Busy, done pulse and sticky verdict flags.
  always_ff @(posedge clk) begin
    if (ar) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      done <= done_n;
      if (load)        busy <= 1'b1;
      else if (done_n) busy <= 1'b0;
      if (clr) begin
        pass    <= 1'b0;
        fail    <= 1'b0;
        timeout <= 1'b0;
      end
      if (set_pass) pass    <= 1'b1;
      if (set_fail) fail    <= 1'b1;
      if (set_to)   timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reaction_responder.sv
// Directed bench for reaction_responder with a verdict scoreboard.
// Expected flags are queued at start and popped on each done.
module tb_reaction_responder;

  typedef struct {
    bit p;
    bit f;
    bit t;
  } exp_t;

  logic       clk;
  logic       ar;
  logic       tick_1k;
  logic       start;
  logic [3:0] delay_h;
  logic [3:0] delay_t;
  logic [3:0] delay_o;
  logic       led_in;
  logic [3:0] res_h;
  logic [3:0] res_t;
  logic [3:0] res_o;
  logic       stop_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic       fail;
  logic       timeout;

  int   tests_run;
  int   tests_failed;
  int   tick_num;
  int   rise_tick;
  int   first_stop;
  int   stop_ticks;
  int   done_tick;
  bit   done_seen;
  exp_t sb[$];

  reaction_responder #(
    .PRESS_TICKS   (50),
    .TOL           (1),
    .TIMEOUT_TICKS (20)
  ) dut (
    .clk      (clk),
    .ar       (ar),
    .tick_1k  (tick_1k),
    .start    (start),
    .delay_h  (delay_h),
    .delay_t  (delay_t),
    .delay_o  (delay_o),
    .led_in   (led_in),
    .res_h    (res_h),
    .res_t    (res_t),
    .res_o    (res_o),
    .stop_out (stop_out),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail     (fail),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: grade every done pulse against the queued verdict.
  always begin
    @(posedge clk);
    #1;
    if (done) begin
      exp_t e;
      done_seen = 1'b1;
      done_tick = tick_num;
      check("sb_nonempty", sb.size(), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pass", pass, e.p);
        check("fail", fail, e.f);
        check("timeout", timeout, e.t);
      end
    end
  end

  task automatic tick_once();
    tick_1k = 1'b1;
    tick_num++;
    @(posedge clk);
    #1;
    tick_1k = 1'b0;
    if (stop_out) begin
      stop_ticks++;
      if (first_stop < 0)
        first_stop = tick_num - rise_tick;
    end
    cyc(3);
  endtask

  task automatic run(
    input logic [3:0] dh,
    input logic [3:0] dt,
    input logic [3:0] dl,
    input logic [3:0] rh,
    input logic [3:0] rt,
    input logic [3:0] ro,
    input int         led_after,
    input bit         ep,
    input bit         ef,
    input bit         eto,
    input int         exp_first,
    input bit         restart
  );
    exp_t e;
    e.p = ep;
    e.f = ef;
    e.t = eto;
    sb.push_back(e);
    delay_h    = dh;
    delay_t    = dt;
    delay_o    = dl;
    res_h      = rh;
    res_t      = rt;
    res_o      = ro;
    led_in     = 1'b0;
    tick_num   = 0;
    rise_tick  = 0;
    first_stop = -1;
    stop_ticks = 0;
    done_seen  = 1'b0;
    done_tick  = -1;
    cyc(2);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int i = 0; i < 1200 && !done_seen; i++) begin
      if (led_after >= 0 && tick_num == led_after
          && !led_in) begin
        led_in    = 1'b1;
        rise_tick = tick_num;
        cyc(3);
      end
      tick_once();
      if (restart && tick_num == 1) begin
        delay_h = 4'd0;
        delay_t = 4'd0;
        delay_o = 4'd0;
        start   = 1'b1;
        cyc(1);
        start   = 1'b0;
      end
    end
    cyc(3);
    check("done_seen", done_seen, 1);
    check("busy_after_done", busy, 0);
    if (eto) begin
      check("timeout_tick", done_tick, 20);
      check("stop_never", stop_ticks, 0);
    end else begin
      check("first_stop", first_stop, exp_first);
      check("press_ticks", stop_ticks, 50);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    ar       = 1'b1;
    tick_1k  = 1'b0;
    start    = 1'b0;
    delay_h  = 4'd0;
    delay_t  = 4'd0;
    delay_o  = 4'd0;
    led_in   = 1'b0;
    res_h    = 4'd0;
    res_t    = 4'd0;
    res_o    = 4'd0;
    tick_num = 0;
    cyc(3);
    check("rst_stop", stop_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail", fail, 0);
    check("rst_timeout", timeout, 0);
    ar = 1'b0;
    cyc(2);

    // delay 250, result 250, LED 10 ticks after start
    run(4'd2, 4'd5, 4'd0, 4'd2, 4'd5, 4'd0,
        10, 1, 0, 0, 251, 0);
    // delay 000, result 002 exceeds tolerance
    run(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2,
        2, 0, 1, 0, 1, 0);
    // delay 100 crosses both borrows
    run(4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 4'd1,
        2, 1, 0, 0, 101, 0);
    // LED never rises
    run(4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 4'd5,
        -1, 0, 1, 1, 0, 0);

    // reset during PRESS after 10 press ticks
    delay_h    = 4'd0;
    delay_t    = 4'd0;
    delay_o    = 4'd5;
    led_in     = 1'b0;
    tick_num   = 0;
    rise_tick  = 0;
    first_stop = -1;
    stop_ticks = 0;
    cyc(2);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    tick_once();
    led_in    = 1'b1;
    rise_tick = tick_num;
    cyc(3);
    for (int i = 0; i < 100 && stop_ticks < 10; i++)
      tick_once();
    check("pre_reset_stop", stop_out, 1);
    ar = 1'b1;
    cyc(1);
    check("mid_rst_stop", stop_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pass", pass, 0);
    check("mid_rst_fail", fail, 0);
    check("mid_rst_timeout", timeout, 0);
    ar = 1'b0;
    cyc(2);

    // clean run afterwards; second start while busy ignored
    run(4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd3,
        2, 1, 0, 0, 4, 1);
    // F/F/F clamps to 999
    run(4'hF, 4'hF, 4'hF, 4'd9, 4'd9, 4'd9,
        2, 1, 0, 0, 1000, 0);
    // result digit A forces fail even though R == D
    run(4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'hA,
        2, 0, 1, 0, 11, 0);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed",
             tests_run, tests_failed);
    $finish;
  end

endmodule
